// File: rtl/kronos_memarb.sv
// kronos_memarb: shares one req/gnt memory port between instruction fetch and load/store.
// Ports: clk/rstz (async active-low reset); instr_* fetch master (addr, req -> gnt, data);
// data_* load/store master (addr, wdata, mask, wr, req -> gnt, rdata); mem_* shared slave port.
// Build option: define KRONOS_MEMARB_FAIR_EN to bound fetch starvation to MAX_DATA_BURST data grants.
module kronos_memarb #(
    parameter int MAX_DATA_BURST = 4
) (
    input  logic        clk,
    input  logic        rstz,
    input  logic [31:0] instr_addr,
    input  logic        instr_req,
    output logic        instr_gnt,
    output logic [31:0] instr_data,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic [3:0]  data_mask,
    input  logic        data_wr,
    input  logic        data_req,
    output logic        data_gnt,
    output logic [31:0] data_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_mask,
    output logic        mem_wr,
    output logic        mem_req,
    input  logic        mem_gnt,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, OWN_I, OWN_D} state_t;
    state_t state, state_nxt;
    logic fair_turn;
`ifdef KRONOS_MEMARB_FAIR_EN
    localparam int SW = $clog2(MAX_DATA_BURST + 1);
    localparam logic [SW-1:0] MAX_B = SW'(MAX_DATA_BURST);
    logic [SW-1:0] dstreak;
    // Counts data grants that happened while a fetch was waiting.
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) dstreak <= '0;
        else if (instr_gnt) dstreak <= '0;
        else if (data_gnt && instr_req && dstreak != MAX_B) dstreak <= dstreak + 1'b1;
        else if (state == IDLE && !instr_req) dstreak <= '0;
    end
    assign fair_turn = dstreak == MAX_B;
`else
    logic unused_burst;
    assign unused_burst = ^MAX_DATA_BURST;
    assign fair_turn = 1'b0;
`endif
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) state <= IDLE;
        else state <= state_nxt;
    end
    // Grants are combinational from mem_gnt; the grant cycle always returns to IDLE so
    // a request still held there is only re-arbitrated on the following cycle.
    always_comb begin
        state_nxt = state;
        mem_req   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_mask  = '0;
        mem_wr    = 1'b0;
        instr_gnt = 1'b0;
        data_gnt  = 1'b0;
        case (state)
            IDLE: state_nxt = (data_req && !(instr_req && fair_turn)) ? OWN_D : instr_req ? OWN_I : IDLE;
            OWN_I: begin
                mem_req   = instr_req;
                mem_addr  = instr_addr;
                mem_mask  = 4'hF;
                instr_gnt = mem_gnt;
                state_nxt = (mem_gnt || !instr_req) ? IDLE : OWN_I;
            end
            OWN_D: begin
                mem_req   = data_req;
                mem_addr  = data_addr;
                mem_wdata = data_wdata;
                mem_mask  = data_mask;
                mem_wr    = data_wr;
                data_gnt  = mem_gnt;
                state_nxt = mem_gnt ? IDLE : OWN_D;
            end
            default: state_nxt = IDLE;
        endcase
    end
    assign instr_data = mem_rdata;
    assign data_rdata = mem_rdata;
endmodule

// File: tb/tb_kronos_memarb.sv
// tb_kronos_memarb: self-checking bench for kronos_memarb with a transaction-level ownership model.
module tb_kronos_memarb;
    logic        clk = 1'b0;
    logic        rstz = 1'b0;
    logic [31:0] instr_addr = '0, data_addr = '0, data_wdata = '0, mem_rdata = '0;
    logic [3:0]  data_mask = '0;
    logic        instr_req = 1'b0, data_req = 1'b0, data_wr = 1'b0;
    logic        instr_gnt, data_gnt, mem_wr, mem_req, mem_gnt;
    logic [31:0] instr_data, data_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_mask;
    logic        mem_auto = 1'b0, auto_gnt = 1'b0, man_gnt = 1'b0;
    int          lat = 1, mcnt = 0;

    always #5 clk = ~clk;
    assign mem_gnt = mem_auto ? auto_gnt : man_gnt;

    kronos_memarb #(.MAX_DATA_BURST(4)) dut (
        .clk(clk), .rstz(rstz),
        .instr_addr(instr_addr), .instr_req(instr_req), .instr_gnt(instr_gnt), .instr_data(instr_data),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_mask(data_mask), .data_wr(data_wr),
        .data_req(data_req), .data_gnt(data_gnt), .data_rdata(data_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_mask(mem_mask), .mem_wr(mem_wr),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_rdata(mem_rdata)
    );

`ifdef KRONOS_MEMARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif
    localparam int MAXB = 4;

    int    n_checks = 0, n_fail = 0;
    string glog = "";
    int    owner = 0, streak = 0;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_mask;
    logic        e_req, e_wr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        instr_req = 1'b0; data_req = 1'b0; data_wr = 1'b0; man_gnt = 1'b0; mem_auto = 1'b0;
        rstz = 1'b0;
        cyc(1);
        rstz = 1'b1;
        cyc(1);
        glog = "";
    endtask

    task automatic wait_gnt(input bit want_i, input int exp_cyc, input string name);
        int n = 0;
        bit hit = 1'b0;
        while (!hit && n < 30) begin
            @(negedge clk);
            n++;
            hit = want_i ? instr_gnt : data_gnt;
        end
        chk(name, 32'(n), 32'(exp_cyc));
    endtask

    // Model: who owns the port (0 none, 1 fetch, 2 data) and the data-grant streak.
    always @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            owner = 0; streak = 0;
        end else if (owner == 0) begin
            if (!instr_req) streak = 0;
            if (data_req && instr_req) owner = (FAIR && streak == MAXB) ? 1 : 2;
            else if (data_req) owner = 2;
            else if (instr_req) owner = 1;
        end else if (owner == 1) begin
            if (mem_gnt) begin owner = 0; streak = 0; end
            else if (!instr_req) owner = 0;
        end else if (mem_gnt) begin
            owner = 0;
            if (instr_req) streak = (streak < MAXB) ? streak + 1 : MAXB;
        end
    end

    always @(negedge clk) begin
        e_req   = owner == 1 ? instr_req  : owner == 2 ? data_req  : 1'b0;
        e_addr  = owner == 1 ? instr_addr : owner == 2 ? data_addr : 32'h0;
        e_mask  = owner == 1 ? 4'hF       : owner == 2 ? data_mask : 4'h0;
        e_wr    = owner == 2 ? data_wr : 1'b0;
        e_wdata = owner == 2 ? data_wdata : 32'h0;
        chk("mem_req", 32'(mem_req), 32'(e_req));
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_mask", 32'(mem_mask), 32'(e_mask));
        chk("mem_wr", 32'(mem_wr), 32'(e_wr));
        if (owner != 1) chk("mem_wdata", mem_wdata, e_wdata);
        chk("instr_gnt", 32'(instr_gnt), 32'(owner == 1 && mem_gnt));
        chk("data_gnt", 32'(data_gnt), 32'(owner == 2 && mem_gnt));
        chk("instr_data", instr_data, mem_rdata);
        chk("data_rdata", data_rdata, mem_rdata);
        if (instr_gnt) glog = {glog, "I"};
        if (data_gnt) glog = {glog, "D"};
    end

    // Memory that grants on the lat-th cycle of a held request.
    initial forever begin
        @(posedge clk);
        #2;
        if (mem_auto && mem_req) begin
            mcnt++;
            auto_gnt = (mcnt == lat);
            if (mcnt == lat) mcnt = 0;
        end else begin
            mcnt = 0;
            auto_gnt = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        string exp_order;
        // Reset held with both requests up.
        data_req = 1'b1; instr_req = 1'b1; data_addr = 32'h44; instr_addr = 32'h40; mem_rdata = 32'h1234_5678;
        cyc(2);
        @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_gnts", 32'({instr_gnt, data_gnt}), 32'h0);
        @(posedge clk); #1;
        rstz = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_req", 32'(mem_req), 32'h1);
        chk("post_rst_addr", mem_addr, 32'h44);
        do_reset();

        // Single fetch, memory grants on 3rd ownership cycle.
        mem_auto = 1'b1; lat = 3; mem_rdata = 32'h0000_0013;
        instr_addr = 32'h100; instr_req = 1'b1;
        wait_gnt(1'b1, 4, "fetch_latency");
        chk("fetch_data", instr_data, 32'h13);
        chk("fetch_addr", mem_addr, 32'h100);
        chk("fetch_no_dgnt", 32'(data_gnt), 32'h0);
        @(posedge clk); #1;
        instr_req = 1'b0;
        cyc(3);
        chk("fetch_log", 32'(glog == "I"), 32'h1);

        // Simultaneous store and fetch: store first, fetch after one IDLE cycle.
        do_reset();
        mem_auto = 1'b1; lat = 1; mem_rdata = 32'hCAFE_F00D;
        instr_addr = 32'h300; instr_req = 1'b1;
        data_addr = 32'h200; data_wdata = 32'hDEAD_BEEF; data_mask = 4'b0011; data_wr = 1'b1; data_req = 1'b1;
        wait_gnt(1'b0, 2, "store_latency");
        chk("store_wr", 32'(mem_wr), 32'h1);
        chk("store_mask", 32'(mem_mask), 32'h3);
        chk("store_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("store_addr", mem_addr, 32'h200);
        chk("store_no_igna", 32'(instr_gnt), 32'h0);
        @(posedge clk); #1;
        data_req = 1'b0; data_wr = 1'b0;
        wait_gnt(1'b1, 2, "fetch_after_store");
        chk("fetch2_mask", 32'(mem_mask), 32'hF);
        chk("fetch2_wr", 32'(mem_wr), 32'h0);
        chk("fetch2_addr", mem_addr, 32'h300);
        @(posedge clk); #1;
        instr_req = 1'b0;
        cyc(2);
        chk("order_DI", 32'(glog == "DI"), 32'h1);

        // Fetch abort, then a late spurious mem_gnt.
        do_reset();
        instr_addr = 32'h500; instr_req = 1'b1;
        @(negedge clk);
        chk("abort_idle_req", 32'(mem_req), 32'h0);
        @(negedge clk);
        chk("abort_own_req", 32'(mem_req), 32'h1);
        @(posedge clk); #1;
        instr_req = 1'b0;
        @(negedge clk);
        chk("abort_req_drop", 32'(mem_req), 32'h0);
        @(posedge clk); #1;
        man_gnt = 1'b1;
        @(negedge clk);
        chk("late_gnt_ignored", 32'(instr_gnt), 32'h0);
        chk("late_gnt_req", 32'(mem_req), 32'h0);
        @(posedge clk); #1;
        man_gnt = 1'b0;
        cyc(1);
        chk("abort_log_empty", 32'(glog.len()), 32'h0);

        // Continuous data with a waiting fetch.
        do_reset();
        mem_auto = 1'b1; lat = 1;
        data_addr = 32'h700; data_mask = 4'hF; data_wr = 1'b0; instr_addr = 32'h800;
        data_req = 1'b1; instr_req = 1'b1;
        for (int i = 0; i < 60 && glog.len() < 10; i++) @(negedge clk);
        exp_order = FAIR ? "DDDDIDDDDI" : "DDDDDDDDDD";
        n_checks++;
        if (glog.len() < 10 || glog.substr(0, 9) != exp_order) begin
            n_fail++;
            $display("FAIL grant_order: got %s expected %s", glog, exp_order);
        end

        // Async reset in the middle of a data ownership.
        do_reset();
        data_addr = 32'h600; data_wdata = 32'h1; data_mask = 4'hF; data_wr = 1'b1; data_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_own", 32'(mem_req), 32'h1);
        @(posedge clk); #2;
        rstz = 1'b0; man_gnt = 1'b1;
        #1;
        chk("midrst_req_drop", 32'(mem_req), 32'h0);
        chk("midrst_no_gnt", 32'(data_gnt), 32'h0);
        chk("midrst_addr", mem_addr, 32'h0);
        man_gnt = 1'b0;
        @(posedge clk); #1;
        rstz = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_resume", 32'(mem_req), 32'h1);
        do_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/kronos_memarb.md
# kronos_memarb

Two-master, one-slave memory arbiter that lets the Kronos core run from a single memory port. It shares one req/gnt memory interface between the instruction-fetch port (IF stage) and the load/store data port (EX/WB stages). It sits between `kronos_core` and the memory, and sequences one transaction at a time through a small ownership FSM. Data requests take priority because a pending load/store stalls the whole pipeline. An optional fairness guard bounds instruction-fetch starvation.

## Interface
- `MAX_DATA_BURST`, default 4: with fairness enabled, the maximum number of consecutive data grants while a fetch is waiting. Legal range is 1–15.
- `clk` in 1: core clock.
- `rstz` in 1: reset, asynchronous, active-low.
- `instr_addr` in 32: fetch address. Must be held stable while `instr_req` is high.
- `instr_req` in 1: fetch request. May drop before grant (branch flush).
- `instr_gnt` out 1: fetch grant, one-cycle pulse. `instr_data` is valid in the same cycle.
- `instr_data` out 32: fetch read data.
- `data_addr` in 32: load/store address. Held stable until grant.
- `data_wdata` in 32: store data.
- `data_mask` in 4: byte enables.
- `data_wr` in 1: 1 = store, 0 = load.
- `data_req` in 1: load/store request. Held until `data_gnt`.
- `data_gnt` out 1: load/store grant pulse. `data_rdata` is valid in the same cycle for loads.
- `data_rdata` out 32: load data.
- `mem_addr` out 32: shared port address.
- `mem_wdata` out 32: shared port store data.
- `mem_mask` out 4: shared port byte enables.
- `mem_wr` out 1: shared port write strobe.
- `mem_req` out 1: shared port request.
- `mem_gnt` in 1: memory grant pulse. Read data is valid in the same cycle.
- `mem_rdata` in 32: memory read data.

## Operation
- Registered FSM with states IDLE, OWN_I, OWN_D, plus a streak counter `dstreak` of `$clog2(MAX_DATA_BURST+1)` bits.
- From IDLE:
  - only `data_req` → OWN_D.
  - only `instr_req` → OWN_I.
  - both → OWN_D, unless fairness is enabled and `dstreak == MAX_DATA_BURST`, in which case → OWN_I.
  - neither → stay in IDLE.
- OWN_x drives `mem_*` from that master's inputs and sets `mem_req = x_req`.
- In IDLE, `mem_req` = 0 and `mem_addr`, `mem_wdata`, `mem_mask`, `mem_wr` = 0.
- In OWN_I, `mem_wr` = 0 and `mem_mask` = 4'hF.
- In OWN_x with `mem_gnt` = 1:
  - `x_gnt` = 1 combinationally; the other master's gnt stays 0.
  - next state is IDLE.
- In OWN_I with `instr_req` = 0 and `mem_gnt` = 0 (flush abort): next state is IDLE and no grant is forwarded.
  - Data may not abort; if `data_req` drops in OWN_D, behaviour is unspecified.
- Grants are never forwarded from IDLE, even if `mem_gnt` is asserted; a spurious `mem_gnt` is ignored.
- `instr_data` and `data_rdata` are wire copies of `mem_rdata` at all times.
- Streak counter rules:
  - On a data grant while `instr_req` = 1, `dstreak` increments, saturating at `MAX_DATA_BURST`.
  - `dstreak` clears on an instr grant.
  - `dstreak` clears on any IDLE cycle with `instr_req` = 0.

## Timing
- Reset (async, immediate):
  - state = IDLE, `dstreak` = 0.
  - `mem_req`, `instr_gnt`, `data_gnt` = 0.
  - all `mem_*` data/address outputs = 0.
- Arbitration latency: a request seen in IDLE at cycle N produces `mem_req` = 1 at cycle N+1.
- Grant latency to the master equals `mem_gnt` latency. The grant is combinational from `mem_gnt` and is never registered.
- Back-to-back throughput: one transaction per 2 cycles with zero-wait memory (gnt cycle → IDLE → OWN).
- The request a master still holds in its grant cycle is not re-arbitrated. Arbitration happens the following IDLE cycle, which prevents a double grant.
- Reset mid-transaction drops `mem_req` asynchronously with no grant. Masters must re-issue.

## Configuration
- `KRONOS_MEMARB_FAIR_EN` defined:
  - the streak counter is compiled in.
  - after `MAX_DATA_BURST` consecutive data grants with a fetch waiting, the next IDLE arbitration goes to the instruction port.
- Not defined:
  - the counter is removed.
  - data always wins ties (strict fixed priority).
  - `MAX_DATA_BURST` is ignored.

## Test plan
- Reset, with `rstz` low while both requests are high: all outputs are 0. After release the FSM enters OWN_D in the first cycle, so `mem_req` = 1 and `mem_addr` = `data_addr` one cycle after reset.
- Single fetch to 0x100, memory grants on the 3rd cycle of ownership: `instr_gnt` pulses once with `instr_data` = `mem_rdata` (e.g. 0x00000013); `data_gnt` stays 0.
- Simultaneous fetch and store 0xDEADBEEF to 0x200 with mask 4'b0011: the store is granted first with `mem_wr` = 1 and `mem_mask` = 4'b0011, then the fetch is granted after one IDLE cycle.
- Fetch abort: `instr_req` drops in OWN_I before `mem_gnt`. The FSM returns to IDLE next cycle, `mem_req` = 0, and a late `mem_gnt` produces no `instr_gnt`.
- Fairness (`KRONOS_MEMARB_FAIR_EN`, `MAX_DATA_BURST` = 4) with continuous data requests and a waiting fetch: grant order is D,D,D,D,I,D,D,D,D,I. With the macro undefined, the fetch is never granted while data requests persist.
- Async reset asserted mid-OWN_D: `mem_req` drops in the same cycle, `data_gnt` stays 0, and the FSM resumes from IDLE after release.
